io_seg_display: RTL

- Memory-mapped 8-digit 7-segment display controller.
- Sits directly downstream of MemOrIO. It consumes the segment chip-select, ioRead/ioWrite, the low address bits and the 32-bit write_data.
- Returns readback on the 16-bit io_rdata bus.
- Holds display data and control registers, and time-multiplexes the eight digits with a scan divider and a blink timer.

---
 rtl/io_seg_display.sv | 76 +++++++
 1 files changed

// File: rtl/io_seg_display.sv
// io_seg_display: memory-mapped 8-digit multiplexed 7-segment display controller
module io_seg_display #(
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_TICKS = 500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        SegCtrl,
  input  logic        ioWrite,
  input  logic        ioRead,
  input  logic [2:0]  addr_low,
  input  logic [31:0] write_data,
  output logic [15:0] io_rdata,
  output logic [7:0]  seg_out,
  output logic [7:0]  seg_en
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [31:0]   data_q;
  logic [9:0]    ctrl_q;
  logic [DW-1:0] div_q;
  logic [BW-1:0] blk_q;
  logic [2:0]    idx_q;
  logic          phase_q;
  logic [7:0]    seg_en_q, seg_out_q, seg_en_d, seg_out_d;
  logic          tick, wr, rd, lz, blank;
  logic [3:0]    nib;
  assign tick     = div_q == DIV_LAST;
  assign wr       = SegCtrl & ioWrite;
  assign rd       = SegCtrl & ioRead;
  assign seg_en   = seg_en_q;
  assign seg_out  = seg_out_q;
  // Combinational readback; returns register contents before any same-cycle write
  always_comb begin
    io_rdata = !rd                ? 16'h0 :
               addr_low == 3'd0   ? data_q[15:0] :
               addr_low == 3'd2   ? data_q[31:16] :
               addr_low == 3'd4   ? {6'b0, ctrl_q} : 16'h0;
  end
  // Blanking and segment decode for the digit currently being scanned
  always_comb begin
    nib       = data_q[{idx_q, 2'b00} +: 4];
    lz        = (data_q >> {idx_q, 2'b00}) == 32'd0;
    blank     = !ctrl_q[idx_q] | (ctrl_q[8] & phase_q) | (ctrl_q[9] & (idx_q != 3'd0) & lz);
    seg_en_d  = blank ? 8'hFF : ~(8'b1 << idx_q);
    seg_out_d = blank ? 8'hFF : {1'b1, HEX[nib]};
  end
  // Register file, scan/blink timers and registered display outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q    <= 32'h0;
      ctrl_q    <= 10'h0FF;
      div_q     <= '0;
      blk_q     <= '0;
      idx_q     <= 3'd0;
      phase_q   <= 1'b0;
      seg_en_q  <= 8'hFF;
      seg_out_q <= 8'hFF;
    end else begin
      if (wr && addr_low == 3'd0) data_q <= write_data;
      if (wr && addr_low == 3'd4) ctrl_q <= write_data[9:0];
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) begin
        idx_q   <= idx_q + 3'd1;
        blk_q   <= blk_q == BLK_LAST ? '0 : blk_q + 1'b1;
        phase_q <= phase_q ^ (blk_q == BLK_LAST);
      end
      seg_en_q  <= seg_en_d;
      seg_out_q <= seg_out_d;
    end
  end
endmodule
